// File: rtl/mem_cmd_master.sv
// Command initiator for the TCAM/SRAM routing memory: expands host requests into
// registered Mem mode-bus beat sequences and returns read data in order.
module mem_cmd_master #(
  parameter int AddressSize = 4,
  parameter int Bits        = 8,
  parameter int ID_Width    = 4,
  parameter int LEN_W       = 4,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [Bits-1:0]        req_data,
  input  logic [Bits-1:0]        req_mskb,
  input  logic [AddressSize-1:0] req_addr,
  input  logic                   req_dcs,
  input  logic                   req_vbe,
  input  logic                   req_vbi,
  input  logic                   req_inc,
  input  logic [LEN_W-1:0]       req_len,
  output logic [2:0]             MODE,
  output logic [Bits-1:0]        Data_Out,
  output logic [Bits-1:0]        Mskb_Out,
  output logic [AddressSize-1:0] A_Out,
  output logic                   Dcs_Out,
  output logic                   Vbe_Out,
  output logic                   Vbi_Out,
  output logic [ID_Width-1:0]    PacketID_Out,
  input  logic [Bits-1:0]        mem_rdata,
  output logic                   rsp_valid,
  output logic [AddressSize-1:0] rsp_addr,
  output logic [Bits-1:0]        rsp_data,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RSTH, GAP} state_t;
  typedef enum logic [1:0] {OP_WR = 2'd0, OP_RD = 2'd1, OP_RST = 2'd2, OP_FIRE = 2'd3} op_t;
  typedef enum logic [2:0] {
    M_I = 3'b000, M_W = 3'b001, M_R = 3'b010, M_F = 3'b011, M_RST = 3'b101
  } mode_t;

  state_t                   state;
  op_t                      op_q;
  logic [Bits-1:0]          data_q, mskb_q;
  logic [AddressSize-1:0]   addr_q;
  logic                     dcs_q, vbe_q, vbi_q, inc_q;
  logic [LEN_W-1:0]         len_q, k_q;
  logic                     rst_cnt;

  logic [RD_LAT-1:0]                  rd_vld;
  logic [RD_LAT-1:0][AddressSize-1:0] rd_adr;

  op_t                    b_op;
  logic [Bits-1:0]        b_data, b_mskb;
  logic [AddressSize-1:0] b_addr;
  logic                   b_dcs, b_vbe, b_vbi, b_inc;
  logic [LEN_W-1:0]       b_k;
  logic [ID_Width-1:0]    b_kid;

  mode_t                  n_mode;
  logic [Bits-1:0]        n_data, n_mskb;
  logic [AddressSize-1:0] n_a;
  logic                   n_dcs, n_vbe, n_vbi;
  logic [ID_Width-1:0]    n_pid;

  logic accept, last, drive, to_gap, rd_push, outstanding;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Beat source: live request fields for beat 0 at acceptance, latched fields after.
  always_comb begin
    accept = (state == IDLE) && req_valid;
    last   = (k_q == len_q);
    if (state == IDLE) begin
      b_op   = op_t'(req_op);
      b_data = req_data;
      b_mskb = req_mskb;
      b_addr = req_addr;
      b_dcs  = req_dcs;
      b_vbe  = req_vbe;
      b_vbi  = req_vbi;
      b_inc  = req_inc;
      b_k    = '0;
    end else begin
      b_op   = op_q;
      b_data = data_q;
      b_mskb = mskb_q;
      b_addr = addr_q;
      b_dcs  = dcs_q;
      b_vbe  = vbe_q;
      b_vbi  = vbi_q;
      b_inc  = inc_q;
      b_k    = k_q + LEN_W'(1);
    end
    b_kid = ID_Width'(b_k);

    n_mode = M_I;
    n_data = '0;
    n_mskb = '0;
    n_a    = '0;
    n_dcs  = 1'b0;
    n_vbe  = 1'b0;
    n_vbi  = 1'b0;
    n_pid  = '0;
    case (b_op)
      OP_WR: begin
        n_mode = M_W;
        n_a    = b_addr + AddressSize'(b_k);
        n_mskb = b_mskb;
        n_dcs  = b_dcs;
        n_vbe  = b_vbe;
        n_vbi  = b_vbi;
        n_data = b_data;
        if (b_inc) begin
          // Upper and lower ID fields advance independently; no carry between them.
          n_data[ID_Width-1:0]    = b_data[ID_Width-1:0] + b_kid;
          n_data[Bits-1 -: ID_Width] = b_data[Bits-1 -: ID_Width] + b_kid;
        end
      end
      OP_RD: begin
        n_mode = M_R;
        n_a    = b_addr + AddressSize'(b_k);
        n_dcs  = b_dcs;
        n_vbe  = b_vbe;
      end
      OP_FIRE: begin
        n_mode = M_F;
        n_a    = b_addr + AddressSize'(b_k);
        n_dcs  = b_dcs;
        n_pid  = b_data[ID_Width-1:0] + b_kid;
      end
      OP_RST: begin
        n_mode = M_RST;
      end
    endcase

    drive       = accept || ((state == ISSUE) && !last);
    to_gap      = ((state == ISSUE) && last) || ((state == RSTH) && rst_cnt);
    rd_push     = drive && (b_op == OP_RD);
    outstanding = |rd_vld;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= OP_WR;
      data_q       <= '0;
      mskb_q       <= '0;
      addr_q       <= '0;
      dcs_q        <= 1'b0;
      vbe_q        <= 1'b0;
      vbi_q        <= 1'b0;
      inc_q        <= 1'b0;
      len_q        <= '0;
      k_q          <= '0;
      rst_cnt      <= 1'b0;
      MODE         <= M_I;
      Data_Out     <= '0;
      Mskb_Out     <= '0;
      A_Out        <= '0;
      Dcs_Out      <= 1'b0;
      Vbe_Out      <= 1'b0;
      Vbi_Out      <= 1'b0;
      PacketID_Out <= '0;
      rd_vld       <= '0;
      rd_adr       <= '0;
      rsp_valid    <= 1'b0;
      rsp_addr     <= '0;
      rsp_data     <= '0;
    end else begin
      // Read-latency pipe: stage 0 takes the beat registered at this edge.
      rd_vld    <= RD_LAT'({rd_vld, rd_push});
      rd_adr    <= (RD_LAT * AddressSize)'({rd_adr, n_a});
      rsp_valid <= rd_vld[RD_LAT-1];
      if (rd_vld[RD_LAT-1]) begin
        rsp_addr <= rd_adr[RD_LAT-1];
        rsp_data <= mem_rdata;
      end

      if (drive) begin
        MODE         <= n_mode;
        Data_Out     <= n_data;
        Mskb_Out     <= n_mskb;
        A_Out        <= n_a;
        Dcs_Out      <= n_dcs;
        Vbe_Out      <= n_vbe;
        Vbi_Out      <= n_vbi;
        PacketID_Out <= n_pid;
      end else if (to_gap) begin
        MODE         <= M_I;
        Data_Out     <= '0;
        Mskb_Out     <= '0;
        A_Out        <= '0;
        Vbe_Out      <= 1'b0;
        Vbi_Out      <= 1'b0;
        PacketID_Out <= '0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= b_op;
            data_q  <= req_data;
            mskb_q  <= req_mskb;
            addr_q  <= req_addr;
            dcs_q   <= req_dcs;
            vbe_q   <= req_vbe;
            vbi_q   <= req_vbi;
            inc_q   <= req_inc;
            len_q   <= req_len;
            k_q     <= '0;
            rst_cnt <= 1'b0;
            state   <= (b_op == OP_RST) ? RSTH : ISSUE;
          end
        end
        ISSUE: begin
          if (last) state <= GAP;
          else      k_q   <= k_q + LEN_W'(1);
        end
        RSTH: begin
          if (rst_cnt) state   <= GAP;
          else         rst_cnt <= 1'b1;
        end
        GAP: begin
          if (!outstanding) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_master.sv
// Bench for mem_cmd_master: expected Mem beats and read responses are queued at
// request time and consumed by a negedge monitor; per-scenario tasks check the rest.
module tb_mem_cmd_master;
  localparam int AW = 4, BW = 8, IW = 4, LW = 4, RL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [BW-1:0] req_data, req_mskb;
  logic [AW-1:0] req_addr;
  logic          req_dcs, req_vbe, req_vbi, req_inc;
  logic [LW-1:0] req_len;
  logic [2:0]    MODE;
  logic [BW-1:0] Data_Out, Mskb_Out;
  logic [AW-1:0] A_Out;
  logic          Dcs_Out, Vbe_Out, Vbi_Out;
  logic [IW-1:0] PacketID_Out;
  logic [BW-1:0] mem_rdata;
  logic          rsp_valid;
  logic [AW-1:0] rsp_addr;
  logic [BW-1:0] rsp_data;
  logic          busy;

  always #5 clk = ~clk;

  mem_cmd_master #(
    .AddressSize(AW), .Bits(BW), .ID_Width(IW), .LEN_W(LW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .req_mskb(req_mskb), .req_addr(req_addr),
    .req_dcs(req_dcs), .req_vbe(req_vbe), .req_vbi(req_vbi), .req_inc(req_inc),
    .req_len(req_len), .MODE(MODE), .Data_Out(Data_Out), .Mskb_Out(Mskb_Out),
    .A_Out(A_Out), .Dcs_Out(Dcs_Out), .Vbe_Out(Vbe_Out), .Vbi_Out(Vbi_Out),
    .PacketID_Out(PacketID_Out), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .busy(busy)
  );

  // Memory model: read data for an address is 0xA0 + address, one register behind A_Out.
  logic [AW-1:0] a_d1;
  always @(posedge clk) a_d1 <= A_Out;
  assign mem_rdata = 8'hA0 + {4'h0, a_d1};

  typedef struct packed {
    logic          full;
    logic [2:0]    mode;
    logic [AW-1:0] a;
    logic [BW-1:0] data;
    logic [BW-1:0] mskb;
    logic          dcs, vbe, vbi;
    logic [IW-1:0] pid;
  } beat_t;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    runs  = 0;
  logic [2:0] prev_mode = 3'b000;

  always @(negedge clk) begin
    beat_t eb;
    rsp_t  er;
    if (MODE !== 3'b000) begin
      n_cmp++;
      if (prev_mode === 3'b000) runs++;
      if (beat_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: MODE=%b A=%h, required no beat", MODE, A_Out);
      end else begin
        eb = beat_q.pop_front();
        if (MODE !== eb.mode || PacketID_Out !== eb.pid ||
            (eb.full && {A_Out, Data_Out, Mskb_Out, Dcs_Out, Vbe_Out, Vbi_Out} !==
                        {eb.a, eb.data, eb.mskb, eb.dcs, eb.vbe, eb.vbi})) begin
          n_err++;
          $display("FAIL beat: got mode=%b a=%h d=%h m=%h dcs=%b vbe=%b vbi=%b pid=%h, required mode=%b a=%h d=%h m=%h dcs=%b vbe=%b vbi=%b pid=%h",
                   MODE, A_Out, Data_Out, Mskb_Out, Dcs_Out, Vbe_Out, Vbi_Out, PacketID_Out,
                   eb.mode, eb.a, eb.data, eb.mskb, eb.dcs, eb.vbe, eb.vbi, eb.pid);
        end
      end
    end
    prev_mode = MODE;
    if (rsp_valid !== 1'b0) begin
      n_cmp++;
      if (rsp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: rsp_valid=%b addr=%h data=%h, required no response",
                 rsp_valid, rsp_addr, rsp_data);
      end else begin
        er = rsp_q.pop_front();
        if ({rsp_addr, rsp_data} !== {er.a, er.d}) begin
          n_err++;
          $display("FAIL rsp: got addr=%h data=%h, required addr=%h data=%h",
                   rsp_addr, rsp_data, er.a, er.d);
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [7:0] data, input logic [7:0] mskb,
                        input logic [3:0] addr, input logic dcs, input logic vbe,
                        input logic vbi, input logic inc, input logic [3:0] len);
    int    w = 0;
    int    nb;
    beat_t b;
    @(negedge clk);
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (req_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_ready_timeout: req_ready=%b, required 1", req_ready);
    end
    nb = (op == 2'd2) ? 2 : int'(len) + 1;
    for (int k = 0; k < nb; k++) begin
      b = '0;
      b.full = 1'b1;
      case (op)
        2'd0: begin
          b.mode = 3'b001;
          b.a    = addr + 4'(k);
          b.mskb = mskb;
          b.dcs  = dcs;
          b.vbe  = vbe;
          b.vbi  = vbi;
          b.data = inc ? {data[7:4] + 4'(k), data[3:0] + 4'(k)} : data;
        end
        2'd1: begin
          b.mode = 3'b010;
          b.a    = addr + 4'(k);
          b.dcs  = dcs;
          b.vbe  = vbe;
          rsp_q.push_back({b.a, 8'hA0 + {4'h0, b.a}});
        end
        2'd2: begin
          b.mode = 3'b101;
          b.full = 1'b0;
        end
        default: begin
          b.mode = 3'b011;
          b.full = 1'b0;
          b.pid  = data[3:0] + 4'(k);
        end
      endcase
      beat_q.push_back(b);
    end
    req_op = op; req_data = data; req_mskb = mskb; req_addr = addr;
    req_dcs = dcs; req_vbe = vbe; req_vbi = vbi; req_inc = inc; req_len = len;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (busy !== 1'b0 && w < 60);
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_op = 2'd0; req_data = 8'h5A; req_mskb = 8'hFF; req_addr = 4'h3;
    req_dcs = 1'b1; req_vbe = 1'b1; req_vbi = 1'b1; req_inc = 1'b0; req_len = 4'h2;
    @(negedge clk);
    n_cmp++;
    if ({MODE, busy, rsp_valid, Vbe_Out, Dcs_Out} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: mode=%b busy=%b rsp_valid=%b vbe=%b dcs=%b, required all 0",
               MODE, busy, rsp_valid, Vbe_Out, Dcs_Out);
    end
    @(negedge clk);
    n_cmp++;
    if ({Data_Out, A_Out, PacketID_Out, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_fields: data=%h a=%h pid=%h busy=%b, required 0",
               Data_Out, A_Out, PacketID_Out, busy);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || MODE !== 3'b000) begin
      n_err++;
      $display("FAIL reset_release: ready=%b busy=%b mode=%b, required 1 0 000",
               req_ready, busy, MODE);
    end
  endtask

  task automatic test_single_wr();
    do_req(2'd0, 8'h00, 8'hFF, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_wr_busy_beat: busy=%b, required 1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (MODE !== 3'b000 || Dcs_Out !== 1'b1 || Vbe_Out !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_wr_gap: mode=%b dcs=%b vbe=%b busy=%b, required 000 1 0 1",
               MODE, Dcs_Out, Vbe_Out, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || beat_q.size() != 0) begin
      n_err++;
      $display("FAIL single_wr_done: busy=%b pending_beats=%0d, required 0 0", busy, beat_q.size());
    end
  endtask

  task automatic test_wr_burst();
    int nbusy = 0;
    do_req(2'd0, 8'h12, 8'h0F, 4'hE, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
    repeat (4) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
    end
    n_cmp++;
    if (nbusy != 4) begin
      n_err++;
      $display("FAIL wr_burst_busy: busy cycles=%0d, required 4", nbusy);
    end
    @(negedge clk);
    n_cmp++;
    if (MODE !== 3'b000 || A_Out !== 4'h0 || Data_Out !== 8'h00 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL wr_burst_gap: mode=%b a=%h data=%h busy=%b, required 000 0 00 1",
               MODE, A_Out, Data_Out, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || beat_q.size() != 0) begin
      n_err++;
      $display("FAIL wr_burst_done: busy=%b pending_beats=%0d, required 0 0", busy, beat_q.size());
    end
  endtask

  task automatic test_rd_burst();
    int   w = 0;
    logic busy_at_rsp = 1'b0;
    do_req(2'd1, 8'h55, 8'h33, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
    do begin
      @(negedge clk);
      if (rsp_valid === 1'b1) busy_at_rsp = busy;
      w++;
    end while (busy !== 1'b0 && w < 60);
    n_cmp++;
    if (busy !== 1'b0 || rsp_q.size() != 0 || beat_q.size() != 0) begin
      n_err++;
      $display("FAIL rd_burst_done: busy=%b pending_rsp=%0d pending_beats=%0d, required 0 0 0",
               busy, rsp_q.size(), beat_q.size());
    end
    n_cmp++;
    if (busy_at_rsp !== 1'b1) begin
      n_err++;
      $display("FAIL rd_busy_at_last_rsp: busy=%b, required 1", busy_at_rsp);
    end
  endtask

  task automatic test_rst_op();
    do_req(2'd2, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (MODE !== 3'b000 || PacketID_Out !== 4'h0 || beat_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_op_end: mode=%b pid=%h pending_beats=%0d, required 000 0 0",
               MODE, PacketID_Out, beat_q.size());
    end
    wait_idle();
  endtask

  task automatic test_fire();
    do_req(2'd3, 8'h0E, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    repeat (3) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (MODE !== 3'b000 || PacketID_Out !== 4'h0 || beat_q.size() != 0) begin
      n_err++;
      $display("FAIL fire_gap: mode=%b pid=%h pending_beats=%0d, required 000 0 0",
               MODE, PacketID_Out, beat_q.size());
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int runs0 = runs;
    do_req(2'd0, 8'hC3, 8'h81, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    do_req(2'd0, 8'h3C, 8'h18, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    wait_idle();
    n_cmp++;
    if (runs - runs0 != 2 || beat_q.size() != 0) begin
      n_err++;
      $display("FAIL back_to_back_turnaround: op runs=%0d pending_beats=%0d, required 2 0",
               runs - runs0, beat_q.size());
    end
  endtask

  task automatic test_abort();
    do_req(2'd1, 8'h00, 8'h00, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (MODE !== 3'b000 || A_Out !== 4'h0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: mode=%b a=%h busy=%b rsp_valid=%b, required 000 0 0 0",
               MODE, A_Out, busy, rsp_valid);
    end
    n_cmp++;
    if (beat_q.size() != 1 || rsp_q.size() != 3) begin
      n_err++;
      $display("FAIL abort_progress: beats left=%0d rsp left=%0d, required 1 3",
               beat_q.size(), rsp_q.size());
    end
    beat_q.delete();
    rsp_q.delete();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_recover: busy=%b ready=%b, required 0 1", busy, req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_wr();
    test_wr_burst();
    test_rd_burst();
    test_rst_op();
    test_fire();
    test_back_to_back();
    test_abort();
    n_cmp++;
    if (beat_q.size() != 0 || rsp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_queues: beats=%0d rsp=%0d, required 0 0", beat_q.size(), rsp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
